up_down_counter: RTL and testbench



---
 rtl/up_down_counter_pkg.sv | 11 +
 rtl/up_down_counter.sv | 40 ++++
 tb/tb_up_down_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the up/down counter: direction encoding and default width.
package up_down_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/up_down_counter.sv
// N-bit wrapping up/down counter with enable, pause and direction control.
// The count comes straight from a register that asynchronous reset clears.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         pause,
    input  logic         up_down,
    output logic [N-1:0] count
);

    localparam logic [N-1:0] ONE = N'(1);

    // Priority: enable gates everything, then pause, then direction.
    // Unsigned N-bit arithmetic wraps naturally in both directions.
    function automatic logic [N-1:0] next_count(
        input logic [N-1:0] cur,
        input logic         en,
        input logic         pa,
        input dir_e         dir
    );
        logic [N-1:0] nxt;
        nxt = cur;
        if (en && !pa) begin
            if (dir == DIR_UP) nxt = cur + ONE;
            else               nxt = cur - ONE;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= next_count(count, enable, pause, dir_e'(up_down));
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: 4-bit and 8-bit instances share stimulus and are
// scored against a reference model through expected-value queues.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       pause = 1'b0;
    logic       up_down = 1'b0;
    logic [3:0] count4;
    logic [7:0] count8;

    up_down_counter #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .pause(pause), .up_down(up_down), .count(count4)
    );

    up_down_counter #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable),
        .pause(pause), .up_down(up_down), .count(count8)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] m4 = '0;
    logic [7:0] m8 = '0;
    logic [3:0] q4[$];
    logic [7:0] q8[$];

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s (N=4): count=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s (N=8): count=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive inputs, advance the model and queue the value expected after the next edge.
    task automatic drive(input logic r, input logic en, input logic pa, input logic ud);
        reset   = r;
        enable  = en;
        pause   = pa;
        up_down = ud;
        if (r) begin
            m4 = '0;
            m8 = '0;
        end else if (en && !pa) begin
            if (ud) begin
                m4 = m4 + 4'd1;
                m8 = m8 + 8'd1;
            end else begin
                m4 = m4 - 4'd1;
                m8 = m8 - 8'd1;
            end
        end
        q4.push_back(m4);
        q8.push_back(m8);
    endtask

    task automatic step(input string tag, input logic r, input logic en,
                        input logic pa, input logic ud);
        @(negedge clk);
        drive(r, en, pa, ud);
        @(posedge clk);
        #1;
        check4(tag, count4, q4.pop_front());
        check8(tag, count8, q8.pop_front());
    endtask

    initial begin
        // Reset held across the first edge
        reset = 1'b1;
        @(posedge clk);
        #1;
        check4("reset_state", count4, 4'd0);
        check8("reset_state", count8, 8'd0);

        step("release_idle", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("count_up", 0, 1, 0, 1);
        check4("up_reaches_5", count4, 4'd5);
        for (int i = 0; i < 2; i++) step("pause_hold", 0, 1, 1, 1);
        for (int i = 0; i < 2; i++) step("resume_up", 0, 1, 0, 1);
        check4("resume_reaches_7", count4, 4'd7);
        for (int i = 0; i < 5; i++) step("count_down", 0, 1, 0, 0);
        check8("down_reaches_2", count8, 8'd2);
        step("disable_hold", 0, 0, 0, 1);
        step("disable_ignores_pause", 0, 0, 1, 0);

        // Asynchronous reset between edges
        @(negedge clk);
        #5;
        reset = 1'b1;
        m4 = '0;
        m8 = '0;
        #1;
        check4("async_reset", count4, 4'd0);
        check8("async_reset", count8, 8'd0);

        step("reset_held_enabled", 1, 1, 0, 1);
        step("underflow_wrap", 0, 1, 0, 0);
        check4("underflow_is_15", count4, 4'd15);
        check8("underflow_is_255", count8, 8'd255);
        step("hold_at_max", 0, 0, 1, 0);
        step("overflow_wrap", 0, 1, 0, 1);
        check4("overflow_is_0", count4, 4'd0);
        step("dir_change_down", 0, 1, 0, 0);
        step("dir_change_up", 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) step("long_up", 0, 1, 0, 1);
        for (int i = 0; i < 7; i++)  step("mixed", 0, 1, i[0], i[1]);

        checks++;
        assert (q4.size() == 0 && q8.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: pending=%0d expected=0", q4.size() + q8.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
